ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Loads a configuration bitstream into a configuration-chain segment and reads it back. The segment is a serial flip-flop chain entered at `ccff_head` and left at `ccff_tail`, as used by connection-block and switch-block memories. The loader sits between the bitstream source (the host or config controller) and the chain head. It accepts bitstream words over a valid/ready stream and serialises them LSB-first onto the chain. It also performs non-destructive readback: it recirculates the chain through `ccff_tail` and streams the recovered words out.

## Interface
- `DATA_WIDTH`, 8: width of bitstream input and readback output words.
- `CHAIN_LEN`, 10: number of flops in the attached chain (10 for a 3+3+2+2-bit mux-memory segment); must be ≥1.

- `prog_clk`  in  1  programming clock; all state on rising edge.
- `prog_reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  start request.
- `cmd_read`  in  1  0 = load, 1 = readback; qualified by `cmd_valid`.
- `cmd_ready`  out  1  high only in IDLE.
- `s_valid`  in  1  bitstream word valid.
- `s_data`  in  DATA_WIDTH  bitstream word; bit 0 is shifted first.
- `s_ready`  out  1  high only in LOAD_FETCH.
- `m_valid`  out  1  readback word valid; high only in READ_EMIT.
- `m_data`  out  DATA_WIDTH  readback word; bit 0 is the first bit recovered.
- `m_ready`  in  1  readback consumer ready.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_shift_en`  out  1  chain advances one position on each `prog_clk` edge where high; goes to the chain clock gate.
- `ccff_tail`  in  1  serial data from the chain's last flop.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
- Counters:
  - Bit counter `bits_left`: width $clog2(CHAIN_LEN+1).
  - Word-bit index: width $clog2(DATA_WIDTH+1).
  - Words per operation = ceil(CHAIN_LEN/DATA_WIDTH). Only the last word can be partial.
- **IDLE**
  - When `cmd_valid` is high: latch `cmd_read`, set `bits_left = CHAIN_LEN`.
  - Go to LOAD_FETCH (load) or READ_SHIFT (readback).
- **LOAD_FETCH**
  - `s_ready` = 1.
  - On `s_valid & s_ready`: copy `s_data` into the shift register, set `n = min(DATA_WIDTH, bits_left)`, go to LOAD_SHIFT.
- **LOAD_SHIFT**
  - Each cycle: `ccff_shift_en` = 1, `ccff_head` = shift register bit 0; shift register shifts right; `bits_left` and `n` each decrement.
  - When `n` reaches 0: go to DONE if `bits_left` = 0, otherwise LOAD_FETCH.
  - Bits of the final word above the remaining count are discarded.
- **READ_SHIFT**
  - Each cycle: `ccff_shift_en` = 1 and `ccff_head` = `ccff_tail`. This path is combinational, so the chain rotates in place.
  - `ccff_tail` is captured into capture-register bit `i`; `i` increments, `bits_left` decrements.
  - When `i` = DATA_WIDTH or `bits_left` = 0: go to READ_EMIT.
- **READ_EMIT**
  - `m_valid` = 1; `m_data` = capture register. Unfilled upper bits are 0.
  - The chain is frozen: `ccff_shift_en` = 0.
  - On `m_ready`: clear the capture register and `i`; go to DONE if `bits_left` = 0, otherwise READ_SHIFT.
- **DONE**: `done` = 1 for one cycle; return to IDLE.
- Ordering: the first bit loaded ends at the chain's last flop, so readback returns words in load order. A load followed by a readback reproduces the loaded words, with unused upper bits zeroed.
- Commands presented while `busy` are not accepted.
- Outside LOAD_SHIFT/READ_SHIFT: `ccff_shift_en` = 0 and `ccff_head` = 0.

## Timing
- Reset values (asynchronous, apply immediately): state IDLE; all counters and registers 0; outputs `ccff_shift_en`, `ccff_head`, `s_ready`, `m_valid`, `done`, `busy` = 0; `m_data` = 0; `cmd_ready` = 1 once reset deasserts.
- Reset during an operation:
  - Shifting stops in the same cycle the reset asserts.
  - Chain contents are then undefined; no recovery is attempted.
- State-derived outputs (`ccff_shift_en`, `s_ready`, `m_valid`, `busy`, `done`) are Moore outputs with no combinational input paths. The exceptions are `ccff_head` in READ_SHIFT and `cmd_ready` (decoded from IDLE).
- Load latency with no stalls:
  - Command accepted at cycle 0; LOAD_FETCH at cycle 1.
  - Each word costs 1 fetch cycle + n shift cycles.
  - `done` pulses in the cycle after the last shift.
  - CHAIN_LEN=10, DATA_WIDTH=8 → `done` at cycle 13.
- Readback latency: CHAIN_LEN shift cycles + one emit cycle per word (with `m_ready` held high) + 1 DONE cycle.
- `m_data` is stable while `m_valid` is high and `m_ready` is low.
- `s_valid` gaps insert LOAD_FETCH cycles with `ccff_shift_en` = 0.
- CHAIN_LEN < DATA_WIDTH: the operation is one partial word.
- CHAIN_LEN a multiple of DATA_WIDTH: no partial word.

## Test plan
- Load 0xA5, 0x02 (CHAIN_LEN=10) → exactly 10 `ccff_shift_en` cycles; `ccff_head` = 1,0,1,0,0,1,0,1,0,1; `done` at cycle 13.
- Load 0xA5, 0xFE → only bits 0–1 of the second word (0, 1) are shifted; the chain model holds the 10-bit pattern 0b10_1010_0101.
- Readback after the 0xA5/0x02 load → `m_data` 0xA5 then 0x02; a second readback returns the same words (non-destructive).
- Hold `m_ready` low for 5 cycles during the first emit → `ccff_shift_en` = 0 and `m_data` = 0xA5 stable throughout; shifting resumes on the handshake.
- `s_valid` low for 3 cycles between words → 3 extra LOAD_FETCH cycles with `s_ready` = 1, no shift; total shifts still 10.
- Assert `prog_reset_n` low after 4 load shifts → all outputs 0 immediately; after release, `cmd_ready` = 1 and a fresh load completes normally.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// Command, bitstream-in and readback-out handshakes of the loader.
// master = host side, slave = loader side.
interface ccff_chain_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_read;
    logic                  cmd_ready;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output cmd_valid,
        output cmd_read,
        input  cmd_ready,
        output s_valid,
        output s_data,
        input  s_ready,
        input  m_valid,
        input  m_data,
        output m_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_read,
        output cmd_ready,
        input  s_valid,
        input  s_data,
        output s_ready,
        output m_valid,
        output m_data,
        input  m_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial loader and non-destructive readback engine
// for a configuration flip-flop chain segment.
module ccff_chain_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int CHAIN_LEN  = 10
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    ccff_chain_loader_if.slave  bus,
    output logic                ccff_head,
    output logic                ccff_shift_en,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LEN = BW'(CHAIN_LEN);
    localparam logic [IW-1:0] DW  = IW'(DATA_WIDTH);
    localparam logic [IW-1:0] I1  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LFETCH,
        S_LSHIFT,
        S_RSHIFT,
        S_REMIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_bits_left;
    logic [IW-1:0]         r_n;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic [DATA_WIDTH-1:0] r_cap;
    logic [IW-1:0]         w_n_load;
    logic                  w_last_bit;
    logic [DATA_WIDTH-1:0] w_tail_bit;

    assign w_last_bit = (r_bits_left == BW'(1));
    assign w_n_load   = (int'(r_bits_left) >= DATA_WIDTH)
                      ? DW : IW'(r_bits_left);
    assign w_tail_bit = {{(DATA_WIDTH-1){1'b0}}, ccff_tail};

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.s_ready   = (r_state == S_LFETCH);
    assign bus.m_valid   = (r_state == S_REMIT);
    assign bus.m_data    = r_cap;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign ccff_shift_en = (r_state == S_LSHIFT)
                        || (r_state == S_RSHIFT);
    // Readback feeds the tail straight back in so the chain rotates.
    assign ccff_head = (r_state == S_LSHIFT) ? r_sreg[0]
                     : (r_state == S_RSHIFT) ? ccff_tail
                     : 1'b0;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_next = bus.cmd_read ? S_RSHIFT : S_LFETCH;
                end
            end
            S_LFETCH: begin
                if (bus.s_valid) begin
                    w_next = S_LSHIFT;
                end
            end
            S_LSHIFT: begin
                if (r_n == I1) begin
                    w_next = w_last_bit ? S_DONE : S_LFETCH;
                end
            end
            S_RSHIFT: begin
                if ((r_idx == DW - I1) || w_last_bit) begin
                    w_next = S_REMIT;
                end
            end
            S_REMIT: begin
                if (bus.m_ready) begin
                    w_next = (r_bits_left == '0) ? S_DONE : S_RSHIFT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_bits_left <= '0;
            r_n         <= '0;
            r_idx       <= '0;
            r_sreg      <= '0;
            r_cap       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_bits_left <= LEN;
                        r_idx       <= '0;
                        r_cap       <= '0;
                    end
                end
                S_LFETCH: begin
                    if (bus.s_valid) begin
                        r_sreg <= bus.s_data;
                        r_n    <= w_n_load;
                    end
                end
                S_LSHIFT: begin
                    r_sreg      <= r_sreg >> 1;
                    r_n         <= r_n - I1;
                    r_bits_left <= r_bits_left - BW'(1);
                end
                S_RSHIFT: begin
                    r_cap       <= r_cap | (w_tail_bit << r_idx);
                    r_idx       <= r_idx + I1;
                    r_bits_left <= r_bits_left - BW'(1);
                end
                S_REMIT: begin
                    if (bus.m_ready) begin
                        r_cap <= '0;
                        r_idx <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader with a behavioural
// chain model and load-order bitstream reference.
module tb_ccff_chain_loader;

    localparam int DW = 8;
    localparam int CL = 10;
    localparam int NW = (CL + DW - 1) / DW;

    logic prog_clk = 1'b0;
    logic prog_reset_n = 1'b0;
    logic ccff_head;
    logic ccff_shift_en;
    logic ccff_tail;
    logic busy;
    logic done;

    ccff_chain_loader_if #(.DATA_WIDTH(DW)) bus();

    ccff_chain_loader #(
        .DATA_WIDTH(DW),
        .CHAIN_LEN (CL)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .bus          (bus),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done)
    );

    always #5 prog_clk = ~prog_clk;

    // Physical chain: index CL-1 is the last flop.
    logic [CL-1:0] chain = '0;
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain[CL-1];

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    bit mem [CL];
    bit exp_head [$];
    logic [DW-1:0] exp_words [$];

    int t0 = 0;
    int shift_cnt = 0;
    int fetch_cnt = 0;
    bit op_read = 1'b0;
    logic [CL-1:0] hist = '0;
    bit prev_hold = 1'b0;
    logic [DW-1:0] prev_m = '0;
    bit eb;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void miss(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected", nm);
    endfunction

    function automatic logic [CL-1:0] mem_vec();
        logic [CL-1:0] v;
        for (int b = 0; b < CL; b++) v[b] = mem[b];
        return v;
    endfunction

    function automatic logic [CL-1:0] chain_load_order();
        logic [CL-1:0] v;
        for (int b = 0; b < CL; b++) v[b] = chain[CL-1-b];
        return v;
    endfunction

    // Per-cycle compare process
    always @(negedge prog_clk) begin
        if (!prog_reset_n) begin
            chk("rst_shift_en", ccff_shift_en, 0);
            chk("rst_head", ccff_head, 0);
            chk("rst_s_ready", bus.s_ready, 0);
            chk("rst_m_valid", bus.m_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_data", bus.m_data, 0);
            prev_hold = 1'b0;
        end else begin
            chk("cmd_ready", bus.cmd_ready, !busy);
            if (bus.cmd_valid && bus.cmd_ready) begin
                t0 = cyc;
                shift_cnt = 0;
                fetch_cnt = 0;
                op_read = bus.cmd_read;
                hist = '0;
            end
            if (bus.s_ready) begin
                fetch_cnt++;
                chk("fetch_excl", {ccff_shift_en, bus.m_valid}, 0);
            end
            if (ccff_shift_en) begin
                if (op_read) begin
                    chk("rd_rotate", ccff_head, ccff_tail);
                end else if (exp_head.size() == 0) begin
                    miss("extra_shift");
                end else begin
                    eb = exp_head.pop_front();
                    chk("head_bit", ccff_head, eb);
                end
                if (!op_read && shift_cnt < CL) hist[shift_cnt] = ccff_head;
                shift_cnt++;
            end else begin
                chk("head_idle", ccff_head, 0);
            end
            if (bus.m_valid) begin
                chk("emit_frozen", ccff_shift_en, 0);
                if (prev_hold) chk("m_stable", bus.m_data, prev_m);
                if (bus.m_ready) begin
                    if (exp_words.size() == 0) miss("extra_word");
                    else chk("m_data", bus.m_data, exp_words.pop_front());
                end
            end else if (prev_hold) begin
                chk("m_valid_held", bus.m_valid, 1);
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_m = bus.m_data;
        end
    end

    task automatic wait_for(input int sel, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge prog_clk);
            if ((sel == 0 && bus.s_ready) || (sel == 1 && done)
             || (sel == 2 && bus.m_valid) || (sel == 3 && bus.cmd_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) $display("FAIL timeout_%s: got none expected event", nm);
        n_tests++;
        if (!ok) n_fail++;
    endtask

    task automatic issue_cmd(input bit rd);
        @(posedge prog_clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_read = rd;
        wait_for(3, "cmd");
        @(posedge prog_clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [DW-1:0] w [NW], input int gap,
                           output int lat);
        for (int b = 0; b < CL; b++) begin
            mem[b] = w[b / DW][b % DW];
            exp_head.push_back(mem[b]);
        end
        issue_cmd(1'b0);
        for (int k = 0; k < NW; k++) begin
            if (k > 0 && gap > 0) begin
                wait_for(0, "gap");
                repeat (gap) @(posedge prog_clk);
                #1;
            end
            bus.s_valid = 1'b1;
            bus.s_data = w[k];
            wait_for(0, "fetch");
            @(posedge prog_clk);
            #1;
            bus.s_valid = 1'b0;
            bus.s_data = DW'($urandom);
        end
        wait_for(1, "load_done");
        lat = cyc - t0;
        chk("load_lat", lat, NW + CL + 1 + gap * (NW - 1));
        chk("load_shifts", shift_cnt, CL);
        chk("load_fetches", fetch_cnt, NW + gap * (NW - 1));
        chk("head_q_empty", exp_head.size(), 0);
        chk("chain_content", chain_load_order(), mem_vec());
    endtask

    task automatic push_read_words();
        logic [DW-1:0] v;
        for (int k = 0; k < NW; k++) begin
            v = '0;
            for (int j = 0; j < DW; j++) begin
                if (k * DW + j < CL) v[j] = mem[k * DW + j];
            end
            exp_words.push_back(v);
        end
    endtask

    task automatic do_read(input bit rnd);
        bit ok;
        push_read_words();
        bus.m_ready = rnd ? 1'($urandom) : 1'b1;
        issue_cmd(1'b1);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge prog_clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge prog_clk);
            #1;
            if (rnd) bus.m_ready = 1'($urandom);
        end
        if (!ok) $display("FAIL timeout_read: no done");
        n_tests++;
        if (!ok) n_fail++;
        if (!rnd) chk("read_lat", cyc - t0, CL + NW + 1);
        chk("read_shifts", shift_cnt, CL);
        chk("words_left", exp_words.size(), 0);
        chk("chain_kept", chain_load_order(), mem_vec());
        bus.m_ready = 1'b1;
    endtask

    logic [DW-1:0] wv [NW];
    int lat;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_read = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        #1;
        chk("por_shift_en", ccff_shift_en, 0);
        chk("por_busy", busy, 0);
        repeat (3) @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        #1;
        chk("rel_cmd_ready", bus.cmd_ready, 1);
        chk("rel_busy", busy, 0);

        wv[0] = 8'hA5;
        wv[1] = 8'h02;
        do_load(wv, 0, lat);
        chk("lit_done_cycle", lat, 13);
        chk("lit_head_seq", hist, 10'h2A5);

        push_read_words();
        chk("lit_model_w0", exp_words[0], 8'hA5);
        chk("lit_model_w1", exp_words[1], 8'h02);
        exp_words.delete();
        do_read(1'b0);
        do_read(1'b0);

        push_read_words();
        bus.m_ready = 1'b0;
        issue_cmd(1'b1);
        wait_for(2, "stall_emit");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge prog_clk);
            chk("stall_m_data", bus.m_data, 8'hA5);
            chk("stall_frozen", ccff_shift_en, 0);
        end
        @(posedge prog_clk);
        #1;
        bus.m_ready = 1'b1;
        wait_for(1, "stall_done");
        chk("stall_words_left", exp_words.size(), 0);
        chk("stall_shifts", shift_cnt, CL);

        wv[0] = 8'hA5;
        wv[1] = 8'hFE;
        do_load(wv, 0, lat);
        chk("lit_trunc_chain", chain_load_order(), 10'h2A5);
        chk("lit_trunc_head", hist, 10'h2A5);

        wv[0] = 8'h3C;
        wv[1] = 8'h01;
        do_load(wv, 3, lat);
        chk("lit_gap_lat", lat, 16);
        chk("lit_gap_fetch", fetch_cnt, 5);
        do_read(1'b0);

        // Abort a load mid-shift with an asynchronous reset.
        issue_cmd(1'b0);
        bus.s_valid = 1'b1;
        bus.s_data = 8'hFF;
        exp_head.delete();
        for (int b = 0; b < CL; b++) exp_head.push_back(1'b1);
        wait_for(0, "rst_fetch");
        @(posedge prog_clk);
        #1;
        bus.s_valid = 1'b0;
        repeat (4) @(posedge prog_clk);
        #3;
        prog_reset_n = 1'b0;
        #1;
        chk("arst_shift_en", ccff_shift_en, 0);
        chk("arst_head", ccff_head, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", bus.s_ready, 0);
        chk("arst_m_valid", bus.m_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_m_data", bus.m_data, 0);
        chk("arst_shift_count", shift_cnt, 4);
        exp_head.delete();
        repeat (2) @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        #1;
        chk("arst_cmd_ready", bus.cmd_ready, 1);

        for (int it = 0; it < 15; it++) begin
            for (int k = 0; k < NW; k++) wv[k] = DW'($urandom);
            do_load(wv, int'($urandom_range(0, 3)), lat);
            do_read(1'($urandom));
            if (it % 4 == 0) do_read(1'b1);
        end

        repeat (2) @(posedge prog_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
